// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   CLA_CHUNK_DEF  default number of bits resolved per pipeline stage
//   CLA_WIDTH_DEF  default operand width
//   cla_stage_t    per-stage pipeline record at the default width
//                  (valid, a, b, partial sum, carry)
//   cla_sat_limit  signed max (neg=0) or signed min (neg=1) for a width,
//                  returned right-aligned in a CLA_MAX_WIDTH vector
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_CHUNK_DEF = 4;
  localparam int CLA_WIDTH_DEF = 16;
  localparam int CLA_MAX_WIDTH = 64;

  typedef struct packed {
    logic                     valid;
    logic [CLA_WIDTH_DEF-1:0] a;
    logic [CLA_WIDTH_DEF-1:0] b;
    logic [CLA_WIDTH_DEF-1:0] sum;
    logic                     carry;
  } cla_stage_t;

  // Signed max is 0111..1, signed min is 1000..0, both within 'width' bits.
  function automatic logic [CLA_MAX_WIDTH-1:0] cla_sat_limit(input int width, input logic neg);
    logic [CLA_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < CLA_MAX_WIDTH; i++) begin
      if (i == width - 1) begin
        v[i] = neg;
      end else if (i < width - 1) begin
        v[i] = ~neg;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub_if
// Operand/result handshake bundle for pipelined_cla_addsub.
//   in_valid/in_ready   operand transfer handshake
//   a, b, cin, sub      operands, carry/borrow-in, subtract select
//   sat                 saturate request (only when CLA_SAT_EN is defined)
//   out_valid/out_ready result transfer handshake
//   sum, cout, ovf      result, carry-out (1 = no borrow in sub), signed ovf
// Modports: slave = the adder, master = the party driving operands and
// consuming results.
// -----------------------------------------------------------------------------
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
`ifdef CLA_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CLA_SAT_EN
  modport slave  (input  in_valid, a, b, cin, sub, sat, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, sub, sat, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`else
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`endif

endinterface

// File: rtl/cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Combinational CHUNK-bit carry-lookahead slice.
//   a, b  slice operand bits
//   ci    carry into the slice
//   s     slice sum bits
//   co    carry out of the slice
// Every internal carry is a flat sum-of-products of generate/propagate terms
// and ci, so no carry ripples through another within the slice.
// -----------------------------------------------------------------------------
module cla_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic             w_term;

  // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (ci & p[0..i]).
  always_comb begin
    w_g    = a & b;
    w_p    = a | b;
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= i; m++) begin
          w_term = w_term & w_p[m];
        end
        w_c[i+1] = w_c[i+1] | w_term;
      end
      w_term = ci;
      for (int m = 0; m <= i; m++) begin
        w_term = w_term & w_p[m];
      end
      w_c[i+1] = w_c[i+1] | w_term;
    end
  end

  assign s  = a ^ b ^ w_c[CHUNK-1:0];
  assign co = w_c[CHUNK];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
// WIDTH-bit pipelined carry-lookahead adder/subtractor. Stage 0 registers the
// conditioned operands; each following stage resolves one CHUNK-bit slice,
// so a result appears NCHUNK accepted-cycles after its operands.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipelined_cla_addsub_if.slave (operand and result handshakes)
// Optional build macro CLA_SAT_EN: adds bus.sat; on signed overflow with
// sat=1 the sum clamps to signed max/min instead of wrapping.
// -----------------------------------------------------------------------------
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = CLA_CHUNK_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipelined_cla_addsub_if.slave        bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LAST   = NCHUNK - 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
    $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Lower sum bits fill in as slices resolve; upper a/b bits wait their turn.
  typedef struct packed {
    logic             valid;
`ifdef CLA_SAT_EN
    logic             sat;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

`ifdef CLA_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(cla_sat_limit(WIDTH, 1'b0));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(cla_sat_limit(WIDTH, 1'b1));
`endif

  stage_t           r_stg [NCHUNK];
  logic [CHUNK-1:0] w_s   [NCHUNK];
  logic [NCHUNK-1:0] w_co;
  logic             w_en;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] w_sum_full;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_cmsb;
  logic             w_ovf_next;

  // One global enable: everything advances unless a result is being held.
  assign w_en          = bus.out_ready | ~r_out_valid;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  for (genvar k = 0; k < NCHUNK; k++) begin : g_slice
    cla_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (r_stg[k].a[k*CHUNK +: CHUNK]),
      .b  (r_stg[k].b[k*CHUNK +: CHUNK]),
      .ci (r_stg[k].carry),
      .s  (w_s[k]),
      .co (w_co[k])
    );
  end

  // Final-slice result, overflow flag and optional saturation.
  always_comb begin
    w_sum_full                     = r_stg[LAST].sum;
    w_sum_full[WIDTH-1 -: CHUNK]   = w_s[LAST];
    // a^b^s at the MSB recovers the carry into the MSB.
    w_cmsb     = r_stg[LAST].a[WIDTH-1] ^ r_stg[LAST].b[WIDTH-1] ^ w_sum_full[WIDTH-1];
    w_ovf_next = w_cmsb ^ w_co[LAST];
    w_sum_next = w_sum_full;
`ifdef CLA_SAT_EN
    // On overflow both operands share a sign, which is the true result's sign.
    if (r_stg[LAST].sat && w_ovf_next) begin
      if (r_stg[LAST].a[WIDTH-1]) begin
        w_sum_next = SAT_MIN;
      end else begin
        w_sum_next = SAT_MAX;
      end
    end else begin
      w_sum_next = w_sum_full;
    end
`endif
  end

  // Pipeline registers: operand conditioning, slice stages and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCHUNK; k++) begin
        r_stg[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_stg[0].valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_stg[0].a     <= bus.a;
        r_stg[0].b     <= bus.sub ? ~bus.b : bus.b;
        r_stg[0].sum   <= '0;
        r_stg[0].carry <= bus.cin ^ bus.sub;
`ifdef CLA_SAT_EN
        r_stg[0].sat   <= bus.sat;
`endif
      end
      for (int k = 0; k < LAST; k++) begin
        r_stg[k+1].valid <= r_stg[k].valid;
        if (r_stg[k].valid) begin
          r_stg[k+1]                         <= r_stg[k];
          r_stg[k+1].sum[k*CHUNK +: CHUNK]   <= w_s[k];
          r_stg[k+1].carry                   <= w_co[k];
        end
      end
      r_out_valid <= r_stg[LAST].valid;
      if (r_stg[LAST].valid) begin
        r_sum  <= w_sum_next;
        r_cout <= w_co[LAST];
        r_ovf  <= w_ovf_next;
      end
    end
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the calculator datapath. It is the WIDTH-bit generalisation of the 4-bit registered CLA adder. Operands are split into CHUNK-bit lookahead slices, and each slice is resolved in its own pipeline stage, so clock rate stays independent of WIDTH. Valid/ready handshakes on both sides support full throughput, backpressure, add/subtract mode and signed overflow/carry flags.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
CHUNK, 4, bits resolved per pipeline stage by one lookahead slice; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transaction offered
in_ready  output  1  block can accept this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: async on rst_n low, all stage valids, out_valid, sum, cout and ovf clear to 0 immediately. In-flight transactions are discarded, nothing is emitted after release, and in_ready is 1 after release.
- Accept: transfer occurs on a rising edge with in_valid && in_ready. in_ready = out_ready || !out_valid (combinational).
- Stall: global enable = in_ready. When out_valid && !out_ready, every stage register holds. Bubbles do not collapse. Outputs stay stable while stalled.
- Operand conditioning (stage 0 register): b_eff = sub ? ~b : b; c_eff = cin ^ sub. Capture a, b_eff, c_eff and valid.
- Stage k (1..NCHUNK): slice k-1 computes per-bit G = a&b, P = a|b, lookahead carries and sum bits from the incoming carry. It registers slice sum, slice carry-out, the already-computed lower sums, and the upper operand bits still pending (skew registers).
- Latency: a transaction accepted on edge n is presented after edge n+NCHUNK, excluding stall cycles (4 cycles for defaults). Throughput is 1 per cycle.
- Flags: cout = carry out of bit WIDTH-1. ovf = carry into MSB XOR carry out of MSB, registered with the last stage.
- Simultaneous accept and output handshake in the same cycle: both complete, and the pipeline advances.
- out_valid is the valid bit of the final stage. The sum, cout and ovf registers update only when enable is high and that stage's input is valid; they otherwise hold their last value.

Optional Feature:
CLA_SAT_EN. When defined, an extra input port sat (1 bit) is captured with the operands. If sat=1 and ovf=1, sum clamps to signed max (0111…1) when the true result is positive, or signed min (1000…0) when it is negative. ovf still reports 1 and cout is unchanged. When undefined, there is no sat port and the result always wraps modulo 2^WIDTH.

Decomposition:
- Shared package cla_pkg holds: the default CHUNK constant, a function returning the signed max/min for a given width, and a packed per-stage struct typedef (valid, a, b, sum, carry).
- One sub-module, cla_slice: a combinational CHUNK-bit lookahead slice with inputs a, b, ci and outputs s, co. It is instantiated NCHUNK times in a generate loop.

Test Plan:
1. Add 0x1234 + 0x0FFF, cin=0, sub=0 -> sum 0x2233, cout 0, ovf 0; out_valid exactly 4 cycles after accept.
2. Add 0x7FFF + 0x0001 -> sum 0x8000, ovf 1, cout 0. With CLA_SAT_EN and sat=1 -> sum 0x7FFF, ovf 1.
3. Sub 0x0005 - 0x0007, cin=0 -> sum 0xFFFE, cout 0, ovf 0. Sub 0x8000 - 0x0001 -> sum 0x7FFF, ovf 1, cout 1.
4. Add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0. The carry crosses all 4 slices.
5. Issue 8 back-to-back ops, dropping out_ready for 3 cycles mid-stream -> in_ready low during the stall, all 8 results in order with no loss or duplication, and outputs stable while stalled.
6. Assert rst_n low with 3 transactions in flight -> out_valid 0 immediately with no clock edge; after release no stale result appears, and the next op emerges with the normal 4-cycle latency.
